result_mul_arbiter: RTL



---
 rtl/result_mul_pkg.sv | 33 +++
 rtl/result_mul_rr_pick.sv | 37 +++
 rtl/result_mul_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/result_mul_pkg.sv
// Shared definitions for the result-instruction multiplier arbiter.
//
// Provides default operand/product widths, the maximum requester count,
// operand/product record types for consumers that want a bundled view,
// and a helper that sizes requester index fields.
package result_mul_pkg;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned MaxNumReq  = 16;
  localparam int unsigned DefAWidth  = 16;
  localparam int unsigned DefBWidth  = 16;
  localparam int unsigned DefPWidth  = DefAWidth + DefBWidth;
  localparam int unsigned MaxIdWidth = 4;

  // Operand pair as captured in the first pipeline stage.
  typedef struct packed {
    logic [DefAWidth-1:0]  a;
    logic [DefBWidth-1:0]  b;
    logic [MaxIdWidth-1:0] id;
  } mul_op_t;

  // Product as presented on the response channel.
  typedef struct packed {
    logic [DefPWidth-1:0]  p;
    logic [MaxIdWidth-1:0] id;
  } mul_prod_t;

  // Width of an index able to address n requesters; never below one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_mul_rr_pick.sv
// Combinational rotating-priority picker.
//
// Searches req_i starting at index ptr_i and wrapping modulo N; the first
// asserted request wins.
//   req_i    N-bit request vector
//   ptr_i    search start index (must be < N)
//   grant_o  one-hot grant (all-zero when nothing requests)
//   idx_o    encoded index of the granted requester (0 when none)
//   any_o    high when at least one request is asserted
module result_mul_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr_i) + k) % int'(N);
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = W'(j);
      end
    end
  end

endmodule

// File: rtl/result_mul_arbiter.sv
// Shared unsigned multiplier with round-robin arbitration.
//
// NUM_REQ requesters present operand pairs on valid/ready channels. One
// winner per cycle is captured into stage S1 (operands + owner id); the
// product is computed between S1 and S2 and held in S2 until the owner
// accepts it. Both stages stall under backpressure, so nothing is lost.
//
// Ports:
//   ap_clk     clock
//   ap_rst     asynchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept, at most one bit high
//   req_a      packed operand A, slice i belongs to requester i
//   req_b      packed operand B, slice i belongs to requester i
//   rsp_valid  one-hot product valid addressed to its owner
//   rsp_ready  per-requester response accept (only the owner's bit matters)
//   rsp_p      product
//   rsp_id     owner index of the presented product
//   busy       any operation in flight
module result_mul_arbiter
  import result_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned A_WIDTH  = DefAWidth,
  parameter int unsigned B_WIDTH  = DefBWidth,
  parameter int unsigned P_WIDTH  = A_WIDTH + B_WIDTH,
  parameter int unsigned ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       busy
);

  // Round-robin pointer.
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  // Stage 1: operands and owner.
  logic                v1_q, v1_d;
  logic [A_WIDTH-1:0]  a1_q, a1_d;
  logic [B_WIDTH-1:0]  b1_q, b1_d;
  logic [ID_WIDTH-1:0] id1_q, id1_d;

  // Stage 2: product and owner.
  logic                v2_q, v2_d;
  logic [P_WIDTH-1:0]  p2_q, p2_d;
  logic [ID_WIDTH-1:0] id2_q, id2_d;

  // Arbiter outputs.
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_any;

  // Handshake terms.
  logic drain;
  logic s1_advance;
  logic s1_can_accept;
  logic accept;

  result_mul_rr_pick #(
    .N (NUM_REQ),
    .W (ID_WIDTH)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A full pipeline frees S1 in the same cycle the owner drains S2, so the
  // drain cycle can both move S1 forward and take a new operand pair.
  always_comb begin
    drain         = v2_q & rsp_ready[id2_q];
    s1_advance    = v1_q & (~v2_q | drain);
    s1_can_accept = ~v1_q | s1_advance;
    accept        = pick_any & s1_can_accept & ~ap_rst;
  end

  // Ready is forced low while reset is held, even though S1 reads empty.
  always_comb begin
    req_ready = '0;
    if (s1_can_accept && !ap_rst) begin
      req_ready = pick_grant;
    end
  end

  // Next state for pointer and both stages.
  always_comb begin
    ptr_d = ptr_q;
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    id1_d = id1_q;
    v2_d  = v2_q;
    p2_d  = p2_q;
    id2_d = id2_q;

    if (drain) begin
      v2_d = 1'b0;
    end
    if (s1_advance) begin
      v2_d  = 1'b1;
      p2_d  = P_WIDTH'(a1_q) * P_WIDTH'(b1_q);
      id2_d = id1_q;
      v1_d  = 1'b0;
    end
    if (accept) begin
      v1_d  = 1'b1;
      a1_d  = req_a[int'(pick_idx)*A_WIDTH +: A_WIDTH];
      b1_d  = req_b[int'(pick_idx)*B_WIDTH +: B_WIDTH];
      id1_d = pick_idx;
      ptr_d = (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q <= '0;
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      id1_q <= '0;
      v2_q  <= 1'b0;
      p2_q  <= '0;
      id2_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      id1_q <= id1_d;
      v2_q  <= v2_d;
      p2_q  <= p2_d;
      id2_q <= id2_d;
    end
  end

  // Response outputs come straight from S2, so they hold while stalled.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid[i] = v2_q && (id2_q == ID_WIDTH'(i));
    end
  end

  assign rsp_p  = p2_q;
  assign rsp_id = id2_q;
  assign busy   = v1_q | v2_q;

endmodule
